booth_mul64_ctrl: RTL and testbench

- Sequential signed 64×64 → 128-bit multiplier controller.
- Runs radix-2 Booth recoding over 64 cycles.
- Uses a single `cla64` instance as its only adder/subtractor. Subtraction is done as `a + ~b + 1`, with `b` inverted and `ci` = 1.
- Sits in the multiplier subsystem between the operand source (register file / testbench) and the shared `cla64` adder. It owns the accumulator, the shift register, the iteration counter and the start/clear/done handshake.

---
 rtl/booth_mul64_ctrl.sv | 155 +++++++++++++++
 tb/tb_booth_mul64_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/booth_mul64_ctrl.sv
// Sequential signed 64x64->128 radix-2 Booth multiplier controller.
// Owns accumulator, shift register, counter and handshake; one shared cla64 does all add/sub.

module cla64 (
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        ci,
    output logic [63:0] s
);
    localparam int unsigned W  = 64;
    localparam int unsigned BW = 4;
    localparam int unsigned NB = W / BW;

    logic [W-1:0] g;
    logic [W-1:0] p;

    assign g = a & b;
    assign p = a ^ b;

    // Block generate/propagate chain across 4-bit groups, local carries within each group.
    always_comb begin
        logic blk_c;
        logic c;
        logic gg;
        logic pp;
        s     = '0;
        blk_c = ci;
        for (int unsigned k = 0; k < NB; k++) begin
            gg = 1'b0;
            pp = 1'b1;
            for (int unsigned j = 0; j < BW; j++) begin
                gg = g[k*BW+j] | (p[k*BW+j] & gg);
                pp = pp & p[k*BW+j];
            end
            c = blk_c;
            for (int unsigned j = 0; j < BW; j++) begin
                s[k*BW+j] = p[k*BW+j] ^ c;
                c         = g[k*BW+j] | (p[k*BW+j] & c);
            end
            blk_c = gg | (pp & blk_c);
        end
    end
endmodule

module booth_mul64_ctrl (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          op_start,
    input  logic          op_clear,
    input  logic [63:0]   multiplier,
    input  logic [63:0]   multiplicand,
    output logic          op_busy,
    output logic          op_done,
    output logic [127:0]  result
);
    localparam int unsigned W  = 64;
    localparam int unsigned CW = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [W-1:0]  u;
    logic [W-1:0]  x;
    logic [W-1:0]  m;
    logic          x_1;
    logic [CW-1:0] cnt;

    logic [W-1:0]  add_b;
    logic          add_ci;
    logic [W-1:0]  sum;
    logic          hold;
    logic          ov;
    logic          sgn;
    logic [W-1:0]  u_new;

    // Booth pair {X[0], x_1}: 01 add M, 10 subtract M, 00/11 pass U through.
    always_comb begin
        hold   = (x[0] == x_1);
        add_ci = x[0] & ~x_1;
        add_b  = add_ci ? ~m : m;
        ov     = (u[W-1] == add_b[W-1]) & (sum[W-1] != u[W-1]);
        sgn    = hold ? u[W-1] : (sum[W-1] ^ ov);
        u_new  = hold ? u : sum;
    end

    cla64 u_cla (
        .a  (u),
        .b  (add_b),
        .ci (add_ci),
        .s  (sum)
    );

    always_comb begin
        state_nxt = state;
        if (op_clear) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE, DONE: if (op_start) state_nxt = EXEC;
                EXEC:       if (cnt == CW'(W - 1)) state_nxt = DONE;
                default:    state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            u       <= '0;
            x       <= '0;
            m       <= '0;
            x_1     <= 1'b0;
            cnt     <= '0;
            op_busy <= 1'b0;
            op_done <= 1'b0;
        end else begin
            state   <= state_nxt;
            op_busy <= (state_nxt == EXEC);
            op_done <= (state_nxt == DONE);
            if (op_clear) begin
                u   <= '0;
                x   <= '0;
                m   <= '0;
                x_1 <= 1'b0;
                cnt <= '0;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (op_start) begin
                            u   <= '0;
                            x   <= multiplier;
                            m   <= multiplicand;
                            x_1 <= 1'b0;
                            cnt <= '0;
                        end
                    end
                    EXEC: begin
                        u   <= {sgn, u_new[W-1:1]};
                        x   <= {u_new[0], x[W-1:1]};
                        x_1 <= x[0];
                        cnt <= cnt + CW'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

    assign result = {u, x};
endmodule

// File: tb/tb_booth_mul64_ctrl.sv
// Self-checking bench for booth_mul64_ctrl: directed table, multi-cycle corner sequences, random vs. arithmetic model.

module tb_booth_mul64_ctrl;
    logic          clk = 1'b0;
    logic          reset_n;
    logic          op_start;
    logic          op_clear;
    logic [63:0]   multiplier;
    logic [63:0]   multiplicand;
    logic          op_busy;
    logic          op_done;
    logic [127:0]  result;

    int n_cmp = 0;
    int n_bad = 0;

    booth_mul64_ctrl dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .op_start     (op_start),
        .op_clear     (op_clear),
        .multiplier   (multiplier),
        .multiplicand (multiplicand),
        .op_busy      (op_busy),
        .op_done      (op_done),
        .result       (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0]  a;
        logic [63:0]  b;
        logic [127:0] exp;
    } vec_t;

    vec_t tbl [6];

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [127:0] model(input logic [63:0] a, input logic [63:0] b);
        logic signed [127:0] sa;
        logic signed [127:0] sb;
        sa = $signed({{64{a[63]}}, a});
        sb = $signed({{64{b[63]}}, b});
        return 128'(sa * sb);
    endfunction

    // From a negedge where op_start has already been sampled: count busy samples until done.
    task automatic wait_done(output int busy_cycles);
        busy_cycles = 0;
        for (int i = 0; i < 200; i++) begin
            if (op_done) break;
            if (op_busy) busy_cycles++;
            @(negedge clk);
        end
    endtask

    task automatic start_op(input logic [63:0] a, input logic [63:0] b);
        @(negedge clk);
        multiplier   = a;
        multiplicand = b;
        op_start     = 1'b1;
        @(negedge clk);
        op_start     = 1'b0;
    endtask

    task automatic do_op(input logic [63:0] a, input logic [63:0] b,
                         output logic [127:0] res, output int busy_cycles);
        start_op(a, b);
        wait_done(busy_cycles);
        res = result;
    endtask

    initial begin
        logic [127:0] res;
        logic [63:0]  ra;
        logic [63:0]  rb;
        int           bc;
        int           cyc;
        logic         saw_done;

        tbl[0] = '{64'd7,             64'd5,                128'd35};
        tbl[1] = '{64'd814,           -64'sd1220,           -128'sd993080};
        tbl[2] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                   128'h4000_0000_0000_0000_0000_0000_0000_0000};
        tbl[3] = '{64'h8000_0000_0000_0000, 64'd1,
                   128'hFFFF_FFFF_FFFF_FFFF_8000_0000_0000_0000};
        tbl[4] = '{64'd0,             64'hFFFF_FFFF_FFFF_FFFF, 128'd0};
        tbl[5] = '{-64'sd1,           -64'sd1,              128'd1};

        reset_n      = 1'b0;
        op_start     = 1'b0;
        op_clear     = 1'b0;
        multiplier   = '0;
        multiplicand = '0;
        #23;
        check("reset busy", 128'(op_busy), 128'd0);
        check("reset done", 128'(op_done), 128'd0);
        check("reset result", result, 128'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            do_op(tbl[i].a, tbl[i].b, res, bc);
            check($sformatf("vec%0d done", i), 128'(op_done), 128'd1);
            check($sformatf("vec%0d busy cycles", i), 128'(bc), 128'd64);
            check($sformatf("vec%0d result", i), res, tbl[i].exp);
        end

        // Back-to-back: 814 x -1220 then start held in DONE with 110080 x 20070.
        do_op(64'd814, -64'sd1220, res, bc);
        check("b2b first", res, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF0_D8C8);
        multiplier   = 64'd110080;
        multiplicand = 64'd20070;
        op_start     = 1'b1;
        @(negedge clk);
        op_start     = 1'b0;
        check("b2b done drop", 128'(op_done), 128'd0);
        check("b2b busy rise", 128'(op_busy), 128'd1);
        wait_done(bc);
        check("b2b busy cycles", 128'(bc), 128'd64);
        check("b2b second", result, 128'd2209305600);

        // Start pulse at cycle 20 of EXEC is ignored.
        start_op(64'd123456789, -64'sd987654321);
        cyc = 0;
        for (int i = 0; i < 200; i++) begin
            if (op_done) break;
            if (op_busy) cyc++;
            if (cyc == 20) begin
                op_start     = 1'b1;
                multiplier   = 64'd3;
                multiplicand = 64'd3;
            end else begin
                op_start = 1'b0;
            end
            @(negedge clk);
        end
        op_start = 1'b0;
        check("midstart busy cycles", 128'(cyc), 128'd64);
        check("midstart result", result, model(64'd123456789, -64'sd987654321));

        // Clear at cycle 30 of EXEC.
        start_op(64'd99, 64'd77);
        repeat (29) @(negedge clk);
        op_clear = 1'b1;
        @(negedge clk);
        op_clear = 1'b0;
        check("clear busy", 128'(op_busy), 128'd0);
        check("clear done", 128'(op_done), 128'd0);
        check("clear result", result, 128'd0);
        saw_done = 1'b0;
        repeat (80) begin
            @(negedge clk);
            saw_done |= op_done;
        end
        check("clear no done", 128'(saw_done), 128'd0);

        // Clear and start together from IDLE.
        multiplier   = 64'd5;
        multiplicand = 64'd6;
        op_start     = 1'b1;
        op_clear     = 1'b1;
        @(negedge clk);
        op_start     = 1'b0;
        op_clear     = 1'b0;
        check("clear+start busy", 128'(op_busy), 128'd0);
        check("clear+start result", result, 128'd0);

        // Asynchronous reset mid-EXEC.
        start_op(64'd1000, 64'd1000);
        repeat (10) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("areset busy", 128'(op_busy), 128'd0);
        check("areset done", 128'(op_done), 128'd0);
        check("areset result", result, 128'd0);
        @(negedge clk);
        reset_n = 1'b1;
        do_op(64'd3, -64'sd3, res, bc);
        check("post reset result", res, -128'sd9);

        // Random operands against the arithmetic model.
        for (int i = 0; i < 20; i++) begin
            ra = {32'($urandom), 32'($urandom)};
            rb = {32'($urandom), 32'($urandom)};
            if (i % 5 == 1) ra = 64'(signed'(32'($urandom)));
            do_op(ra, rb, res, bc);
            check($sformatf("rand%0d result", i), res, model(ra, rb));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
